rmii_rx_fcs_check: RTL and testbench

Downstream stage of the RMII receive path: drains the receive byte FIFO on the user clock side, checks the Ethernet CRC-32 and frame length, strips the 4 FCS bytes, and presents payload bytes as a valid/ready stream with per-frame status on the last byte. The FIFO carries a per-byte End-of-Data flag, and each frame starts at the destination MAC byte; preamble and SFD are already removed.

---
 rtl/rmii_rx_fcs_check_pkg.sv | 24 ++
 rtl/crc32_byte_update.sv | 26 ++
 rtl/rmii_rx_fcs_check.sv | 183 ++++++++++++++++++
 tb/tb_rmii_rx_fcs_check.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_fcs_check_pkg.sv
// Shared constants, state encoding and length helper for the RMII receive FCS checker.
package rmii_rx_fcs_check_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam logic [10:0] MIN_LEN   = 11'd64;
    localparam logic [10:0] MAX_LEN   = 11'd1518;
    localparam logic [10:0] LEN_SAT   = 11'd2047;
    localparam logic [2:0]  FILL_FULL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAP  = 2'd1,
        S_END  = 2'd2
    } state_t;

    // Length bounds include the four FCS bytes.
    function automatic logic len_out_of_range(input logic [10:0] len);
        return (len < MIN_LEN) || (len > MAX_LEN);
    endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational reflected CRC-32 step: next register value after one data byte.
module crc32_byte_update
    import rmii_rx_fcs_check_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    // Eight LSB-first shift/xor steps of the reflected polynomial.
    always_comb begin
        w_crc = i_crc ^ {24'd0, i_data};
        for (int b = 0; b < 8; b++) begin
            if (w_crc[0]) begin
                w_crc = {1'b0, w_crc[31:1]} ^ CRC32_POLY;
            end else begin
                w_crc = {1'b0, w_crc[31:1]};
            end
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/rmii_rx_fcs_check.sv
// Drains the RX byte FIFO, checks CRC-32 and length, strips the FCS and streams
// payload bytes with per-frame status on the last byte.
module rmii_rx_fcs_check
    import rmii_rx_fcs_check_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_EOD_out,
    output logic        fifo_rden,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        m_crc_err,
    output logic        m_len_err,
    output logic [15:0] good_frame_count,
    output logic [15:0] bad_frame_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_rd_ok;
    logic             w_cap;
    logic             w_end;
    logic             w_emit;
    logic [3:0][7:0]  r_dly;
    logic [2:0]       r_fill;
    logic [31:0]      r_crc;
    logic [31:0]      w_crc_next;
    logic [10:0]      r_len;
    logic [10:0]      w_len_inc;
    logic             w_crc_bad;
    logic             w_len_bad;
    logic             r_frm_bad;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_last;
    logic             r_crc_err;
    logic             r_len_err;
    logic [15:0]      r_good_cnt;
    logic [15:0]      r_bad_cnt;
    logic [15:0]      w_good_next;
    logic [15:0]      w_bad_next;

    crc32_byte_update u_crc (
        .i_crc  (r_crc),
        .i_data (fifo_dout),
        .o_crc  (w_crc_next)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_rd_ok) begin
                    w_state_next = S_CAP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CAP: begin
                if (fifo_EOD_out) begin
                    w_state_next = S_END;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_END:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM output decode; a read is only issued when the output slot can take the byte.
    always_comb begin
        w_rd_ok = 1'b0;
        w_cap   = 1'b0;
        w_end   = 1'b0;
        case (r_state)
            S_IDLE:  w_rd_ok = ~rst & ~fifo_empty & (~r_valid | m_ready);
            S_CAP:   w_cap   = 1'b1;
            S_END:   w_end   = 1'b1;
            default: w_rd_ok = 1'b0;
        endcase
    end

    assign fifo_rden = w_rd_ok;
    assign w_len_inc = (r_len == LEN_SAT) ? r_len : (r_len + 11'd1);
    assign w_crc_bad = (w_crc_next != CRC32_RESIDUE);
    assign w_len_bad = len_out_of_range(w_len_inc);
    assign w_emit    = w_cap & (r_fill == FILL_FULL);

    // Delay line, running CRC, length and frame verdict; cleared once per frame in S_END.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly     <= 32'd0;
            r_fill    <= 3'd0;
            r_crc     <= CRC32_INIT;
            r_len     <= 11'd0;
            r_frm_bad <= 1'b0;
        end else if (w_cap) begin
            r_dly <= {r_dly[2:0], fifo_dout};
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + 3'd1;
            end
            r_crc <= w_crc_next;
            r_len <= w_len_inc;
            if (fifo_EOD_out) begin
                r_frm_bad <= w_crc_bad | w_len_bad | (r_fill != FILL_FULL);
            end
        end else if (w_end) begin
            r_fill <= 3'd0;
            r_crc  <= CRC32_INIT;
            r_len  <= 11'd0;
        end
    end

    // Output slot: loads the oldest delayed byte, holds it until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_crc_err <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_emit) begin
            r_data    <= r_dly[3];
            r_valid   <= 1'b1;
            r_last    <= fifo_EOD_out;
            r_crc_err <= fifo_EOD_out & w_crc_bad;
            r_len_err <= fifo_EOD_out & w_len_bad;
        end else if (r_valid & m_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Frame counters advance once per frame; 16-bit arithmetic wraps naturally.
    always_comb begin
        w_good_next = r_good_cnt;
        w_bad_next  = r_bad_cnt;
        if (w_end) begin
            if (r_frm_bad) begin
                w_bad_next = r_bad_cnt + 16'd1;
            end else begin
                w_good_next = r_good_cnt + 16'd1;
            end
        end else begin
            w_good_next = r_good_cnt;
            w_bad_next  = r_bad_cnt;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            r_good_cnt <= w_good_next;
            r_bad_cnt  <= w_bad_next;
        end
    end

    assign m_data           = r_data;
    assign m_valid          = r_valid;
    assign m_last           = r_last;
    assign m_crc_err        = r_crc_err;
    assign m_len_err        = r_len_err;
    assign good_frame_count = r_good_cnt;
    assign bad_frame_count  = r_bad_cnt;

endmodule

// File: tb/tb_rmii_rx_fcs_check.sv
// Directed self-checking bench for rmii_rx_fcs_check with a FIFO model and handshake monitor.
module tb_rmii_rx_fcs_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_EOD_out = 1'b0;
    logic        fifo_rden;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        m_crc_err;
    logic        m_len_err;
    logic [15:0] good_frame_count;
    logic [15:0] bad_frame_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] mem [0:8191];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rden_viol = 0;
    logic [7:0] fb [0:2047];

    logic [7:0] mon_data [0:8191];
    logic       mon_last [0:8191];
    logic       mon_crc  [0:8191];
    logic       mon_len  [0:8191];
    int         mon_n = 0;

    always #5 clk = ~clk;

    rmii_rx_fcs_check dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_empty       (fifo_empty),
        .fifo_dout        (fifo_dout),
        .fifo_EOD_out     (fifo_EOD_out),
        .fifo_rden        (fifo_rden),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last),
        .m_crc_err        (m_crc_err),
        .m_len_err        (m_len_err),
        .good_frame_count (good_frame_count),
        .bad_frame_count  (bad_frame_count)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);

    // FIFO read side: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rden === 1'b1) begin
            if (rd_ptr == wr_ptr) begin
                rden_viol <= rden_viol + 1;
            end else begin
                fifo_dout    <= mem[rd_ptr][7:0];
                fifo_EOD_out <= mem[rd_ptr][8];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    // Records every byte that completes a valid/ready handshake at the next rising edge.
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            mon_data[mon_n] <= m_data;
            mon_last[mon_n] <= m_last;
            mon_crc[mon_n]  <= m_crc_err;
            mon_len[mon_n]  <= m_len_err;
            mon_n           <= mon_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic eod);
        mem[wr_ptr] = {eod, d};
        wr_ptr++;
    endtask

    // Bit-serial reference CRC over fb[0..n-1]; returns the FCS value.
    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        logic        fbit;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fbit = c[0] ^ fb[i][b];
                c    = {1'b0, c[31:1]};
                if (fbit) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic push_frame(input int n);
        logic [31:0] fcs;
        fcs = crc_model(n);
        for (int i = 0; i < n; i++) push_byte(fb[i], 1'b0);
        push_byte(fcs[7:0], 1'b0);
        push_byte(fcs[15:8], 1'b0);
        push_byte(fcs[23:16], 1'b0);
        push_byte(fcs[31:24], 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (rd_ptr != wr_ptr && i < 4000) begin
            tick();
            i++;
        end
        check({tag, "_drain_timeout"}, 32'(i < 4000), 32'd1);
        repeat (8) tick();
    endtask

    task automatic wait_out(input string tag, input int target);
        int i;
        i = 0;
        while (mon_n < target && i < 2000) begin
            tick();
            i++;
        end
        check({tag, "_out_timeout"}, 32'(i < 2000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int start, input int n,
                               input logic crc_e, input logic len_e);
        int bad_d;
        int bad_l;
        bad_d = 0;
        bad_l = 0;
        check({tag, "_count"}, 32'(mon_n - start), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (mon_data[start + i] !== fb[i]) bad_d++;
            if (mon_last[start + i] !== (i == n - 1)) bad_l++;
        end
        check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
        check({tag, "_last_errs"}, 32'(bad_l), 32'd0);
        check({tag, "_crc_err"}, 32'(mon_crc[start + n - 1]), 32'(crc_e));
        check({tag, "_len_err"}, 32'(mon_len[start + n - 1]), 32'(len_e));
    endtask

    initial begin
        string       s;
        logic [31:0] fcs1;
        logic [7:0]  snap_d;
        int          st;
        int          snap_n;
        int          rd_before;
        int          stall_rden;

        // Reset state.
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (3) tick();
        check("rst_rden", 32'(fifo_rden), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_crc_err", 32'(m_crc_err), 32'd0);
        check("rst_len_err", 32'(m_len_err), 32'd0);
        check("rst_good", 32'(good_frame_count), 32'd0);
        check("rst_bad", 32'(bad_frame_count), 32'd0);
        rst = 1'b0;
        tick();

        // "123456789" with its known FCS: short frame, CRC good.
        s = "123456789";
        fcs1 = 32'hCBF4_3926;
        for (int i = 0; i < 9; i++) fb[i] = s[i];
        st = mon_n;
        for (int i = 0; i < 9; i++) push_byte(fb[i], 1'b0);
        push_byte(fcs1[7:0], 1'b0);
        push_byte(fcs1[15:8], 1'b0);
        push_byte(fcs1[23:16], 1'b0);
        push_byte(fcs1[31:24], 1'b1);
        wait_drain("f1");
        check_frame("f1", st, 9, 1'b0, 1'b1);
        check("f1_bad", 32'(bad_frame_count), 32'd1);
        check("f1_good", 32'(good_frame_count), 32'd0);

        // Minimum-length good frame of zeros.
        for (int i = 0; i < 60; i++) fb[i] = 8'h00;
        st = mon_n;
        push_frame(60);
        wait_drain("f2");
        check_frame("f2", st, 60, 1'b0, 1'b0);
        check("f2_good", 32'(good_frame_count), 32'd1);

        // Same frame and FCS with one payload byte corrupted.
        fcs1 = crc_model(60);
        fb[9] = 8'h01;
        st = mon_n;
        for (int i = 0; i < 60; i++) push_byte(fb[i], 1'b0);
        push_byte(fcs1[7:0], 1'b0);
        push_byte(fcs1[15:8], 1'b0);
        push_byte(fcs1[23:16], 1'b0);
        push_byte(fcs1[31:24], 1'b1);
        wait_drain("f3");
        check_frame("f3", st, 60, 1'b1, 1'b0);
        check("f3_bad", 32'(bad_frame_count), 32'd2);

        // Three-byte runt: nothing emitted.
        st = mon_n;
        push_byte(8'hAA, 1'b0);
        push_byte(8'hBB, 1'b0);
        push_byte(8'hCC, 1'b1);
        wait_drain("f4");
        check("f4_no_output", 32'(mon_n - st), 32'd0);
        check("f4_bad", 32'(bad_frame_count), 32'd3);
        check("f4_good", 32'(good_frame_count), 32'd1);

        // Good frame with a 20-cycle downstream stall in the middle.
        for (int i = 0; i < 100; i++) fb[i] = 8'(i * 7 + 3);
        st = mon_n;
        push_frame(100);
        wait_out("f5", st + 10);
        m_ready = 1'b0;
        tick();
        tick();
        snap_d = m_data;
        snap_n = mon_n;
        rd_before = rd_ptr;
        stall_rden = 0;
        repeat (18) begin
            tick();
            if (fifo_rden === 1'b1) stall_rden++;
        end
        check("f5_stall_rden", 32'(stall_rden), 32'd0);
        check("f5_stall_rdptr", 32'(rd_ptr - rd_before), 32'd0);
        check("f5_stall_valid", 32'(m_valid), 32'd1);
        check("f5_stall_data", 32'(m_data), 32'(snap_d));
        check("f5_stall_no_hs", 32'(mon_n - snap_n), 32'd0);
        m_ready = 1'b1;
        wait_drain("f5");
        check_frame("f5", st, 100, 1'b0, 1'b0);
        check("f5_good", 32'(good_frame_count), 32'd2);

        // Reset in the middle of a frame; the tail becomes a bad frame.
        for (int i = 0; i < 60; i++) fb[i] = 8'(i + 64);
        st = mon_n;
        push_frame(60);
        wait_out("f6", st + 3);
        rst = 1'b1;
        tick();
        check("mid_rst_rden", 32'(fifo_rden), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        check("mid_rst_errs", 32'({m_crc_err, m_len_err}), 32'd0);
        check("mid_rst_good", 32'(good_frame_count), 32'd0);
        check("mid_rst_bad", 32'(bad_frame_count), 32'd0);
        rst = 1'b0;
        wait_drain("f6");
        check("f6_tail_bad", 32'(bad_frame_count), 32'd1);
        check("f6_tail_good", 32'(good_frame_count), 32'd0);

        // Preload the good counter to its maximum and let a good frame wrap it.
        force dut.r_good_cnt = 16'hFFFF;
        tick();
        tick();
        release dut.r_good_cnt;
        tick();
        check("wrap_preload", 32'(good_frame_count), 32'h0000_FFFF);
        for (int i = 0; i < 60; i++) fb[i] = 8'h00;
        st = mon_n;
        push_frame(60);
        wait_drain("f7");
        check_frame("f7", st, 60, 1'b0, 1'b0);
        check("wrap_good", 32'(good_frame_count), 32'd0);
        check("wrap_bad", 32'(bad_frame_count), 32'd1);

        check("rden_when_empty", 32'(rden_viol), 32'd0);
        check("final_idle_valid", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
